// File: rtl/uart_file_loader.sv
// ============================================================================
// uart_file_loader
// ----------------------------------------------------------------------------
// Drains the UART receiver FIFO one byte at a time, parses framed load packets
// and writes the assembled 32-bit words into instruction or data memory.
//
// Frame: SYNC, CMD, ADDR_H, ADDR_L, LEN, LEN*4 payload bytes (little-endian),
//        CHK (XOR of CMD .. last payload byte). LEN = 0 means 256 words.
//
// Ports:
//   clk_rx, rst_clk_rx      clock, asynchronous active-high reset
//   rx_data, rx_data_rdy    head byte of the first-word-fall-through FIFO
//   frm_err, lost_data      receiver line-error levels (rising edge matters)
//   read_en                 one-cycle FIFO pop
//   mem_we/sel/addr/wdata   registered memory write port
//   busy                    state is not IDLE
//   load_done               one-cycle pulse on a good checksum
//   err_code                sticky: 0 none, 1 bad cmd, 2 checksum, 3 timeout/line
//   word_count              words written in the last/current frame
// ============================================================================
module uart_file_loader #(
    parameter int          ADDR_W         = 16,
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic              clk_rx,
    input  logic              rst_clk_rx,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_rdy,
    input  logic              frm_err,
    input  logic              lost_data,
    output logic              read_en,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic [1:0]        err_code,
    output logic [8:0]        word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);

    state_t              state;
    state_t              state_next;
    logic                gap;
    logic                frm_err_q;
    logic                lost_data_q;
    logic                line_err;
    logic                consume;
    logic                timeout_hit;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                cmd_sel;
    logic [7:0]          addr_h;
    logic [15:0]         addr_full;
    logic [ADDR_W-1:0]   addr;
    logic [8:0]          remaining;
    logic [1:0]          byte_idx;
    logic [31:0]         asm_word;
    logic [31:0]         next_word;
    logic [7:0]          chk;

    // Line errors only count on their rising edge and only while a frame is
    // being handled; they take priority over consuming a byte that cycle.
    assign line_err    = (state != S_IDLE) &&
                         ((frm_err && !frm_err_q) || (lost_data && !lost_data_q));

    // gap enforces the dead cycle after every pop so the FIFO empty flag can
    // settle. It also resets to 1, which keeps read_en low during reset.
    assign consume     = rx_data_rdy && !gap && !line_err;

    // A byte arriving on the same cycle as the timeout wins.
    assign timeout_hit = !consume && (idle_cnt >= IDLE_LAST);

    assign addr_full   = {addr_h, rx_data};
    assign next_word   = {rx_data, asm_word[31:8]};

    // State register
    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (line_err) begin
            state_next = S_DRAIN;
        end else if (consume) begin
            case (state)
                S_IDLE:    if (rx_data == SYNC_BYTE) state_next = S_CMD;
                S_CMD:     state_next = (rx_data == 8'h01 || rx_data == 8'h02) ? S_ADDR_H : S_DRAIN;
                S_ADDR_H:  state_next = S_ADDR_L;
                S_ADDR_L:  state_next = S_LEN;
                S_LEN:     state_next = S_PAYLOAD;
                S_PAYLOAD: if (byte_idx == 2'd3 && remaining == 9'd1) state_next = S_CHK;
                S_CHK:     state_next = S_IDLE;
                S_DRAIN:   state_next = S_DRAIN;
                default:   state_next = S_IDLE;
            endcase
        end else if (timeout_hit && state != S_IDLE) begin
            // Covers both an aborted frame and the end of draining.
            state_next = S_IDLE;
        end
    end

    // Combinational outputs
    always_comb begin
        read_en = consume;
        busy    = (state != S_IDLE);
    end

    // Datapath: byte pacing, idle timer, field capture, word assembly,
    // checksum and the registered memory write port.
    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            gap         <= 1'b1;
            frm_err_q   <= 1'b0;
            lost_data_q <= 1'b0;
            idle_cnt    <= '0;
            cmd_sel     <= 1'b0;
            addr_h      <= 8'h00;
            addr        <= '0;
            remaining   <= 9'd0;
            byte_idx    <= 2'd0;
            asm_word    <= 32'h0;
            chk         <= 8'h00;
            mem_we      <= 1'b0;
            mem_sel     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0;
            load_done   <= 1'b0;
            err_code    <= 2'd0;
            word_count  <= 9'd0;
        end else begin
            gap         <= consume;
            frm_err_q   <= frm_err;
            lost_data_q <= lost_data;
            mem_we      <= 1'b0;
            load_done   <= 1'b0;

            if (consume || line_err) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (line_err) begin
                err_code <= 2'd3;
            end else if (consume) begin
                case (state)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            err_code   <= 2'd0;
                            word_count <= 9'd0;
                            chk        <= 8'h00;
                        end
                    end
                    S_CMD: begin
                        chk     <= chk ^ rx_data;
                        cmd_sel <= (rx_data == 8'h02);
                        if (rx_data != 8'h01 && rx_data != 8'h02) begin
                            err_code <= 2'd1;
                        end
                    end
                    S_ADDR_H: begin
                        chk    <= chk ^ rx_data;
                        addr_h <= rx_data;
                    end
                    S_ADDR_L: begin
                        chk  <= chk ^ rx_data;
                        addr <= ADDR_W'(addr_full);
                    end
                    S_LEN: begin
                        chk       <= chk ^ rx_data;
                        remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        byte_idx  <= 2'd0;
                    end
                    S_PAYLOAD: begin
                        chk      <= chk ^ rx_data;
                        asm_word <= next_word;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we     <= 1'b1;
                            mem_sel    <= cmd_sel;
                            mem_addr   <= addr;
                            mem_wdata  <= next_word;
                            addr       <= addr + ADDR_W'(1);
                            word_count <= word_count + 9'd1;
                            remaining  <= remaining - 9'd1;
                        end
                    end
                    S_CHK: begin
                        if (rx_data == chk) begin
                            load_done <= 1'b1;
                        end else begin
                            err_code <= 2'd2;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (timeout_hit && state != S_IDLE && state != S_DRAIN) begin
                err_code <= 2'd3;
            end
        end
    end

endmodule

// File: tb/tb_uart_file_loader.sv
// ============================================================================
// tb_uart_file_loader
// ----------------------------------------------------------------------------
// Directed bench for uart_file_loader. A software FIFO feeds rx_data /
// rx_data_rdy and is popped by read_en; a negedge monitor logs memory writes,
// load_done pulses and read_en pacing. The idle timeout is shortened to 100.
// ============================================================================
module tb_uart_file_loader;

    logic        clk_rx = 1'b0;
    logic        rst_clk_rx;
    logic [7:0]  rx_data;
    logic        rx_data_rdy;
    logic        frm_err;
    logic        lost_data;
    logic        read_en;
    logic        mem_we;
    logic        mem_sel;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        load_done;
    logic [1:0]  err_code;
    logic [8:0]  word_count;

    int tests = 0;
    int fails = 0;

    // Software receiver FIFO
    logic [7:0] fifo [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign rx_data_rdy = (rd_ptr != wr_ptr);
    assign rx_data     = fifo[rd_ptr[11:0]];

    // Monitor state
    int          cyc        = 0;
    int          wr_cnt     = 0;
    int          done_cnt   = 0;
    int          back2back  = 0;
    int          rd_empty   = 0;
    int          last_rd_edge = 0;
    int          err3_edge  = 0;
    logic        prev_rd    = 1'b0;
    logic [1:0]  prev_err   = 2'd0;
    logic [15:0] wr_addr [0:1023];
    logic [31:0] wr_data [0:1023];
    logic        wr_sel  [0:1023];

    uart_file_loader #(
        .ADDR_W         (16),
        .TIMEOUT_CYCLES (100),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk_rx      (clk_rx),
        .rst_clk_rx  (rst_clk_rx),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .frm_err     (frm_err),
        .lost_data   (lost_data),
        .read_en     (read_en),
        .mem_we      (mem_we),
        .mem_sel     (mem_sel),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .load_done   (load_done),
        .err_code    (err_code),
        .word_count  (word_count)
    );

    // 100 MHz clock
    always #5 clk_rx = ~clk_rx;

    // Edge counter and FIFO pop
    always @(posedge clk_rx) begin
        cyc <= cyc + 1;
        if (read_en) rd_ptr <= rd_ptr + 1;
    end

    // Output monitor sampled on the falling edge
    always @(negedge clk_rx) begin
        if (mem_we) begin
            if (wr_cnt < 1024) begin
                wr_addr[wr_cnt] <= mem_addr;
                wr_data[wr_cnt] <= mem_wdata;
                wr_sel[wr_cnt]  <= mem_sel;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (load_done) done_cnt <= done_cnt + 1;
        if (read_en && prev_rd) back2back <= back2back + 1;
        if (read_en && !rx_data_rdy) rd_empty <= rd_empty + 1;
        if (read_en) last_rd_edge <= cyc + 1;
        if (err_code == 2'd3 && prev_err != 2'd3) err3_edge <= cyc;
        prev_rd  <= read_en;
        prev_err <= err_code;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifo[wr_ptr[11:0]] = b;
        wr_ptr++;
    endtask

    // Frame A: cmd, address 0x0010, two words, payload 11..44 AA..DD
    task automatic sendFrameA(input logic [7:0] cmd, input logic [7:0] chk);
        applyStimulus(8'hA5);
        applyStimulus(cmd);
        applyStimulus(8'h00);
        applyStimulus(8'h10);
        applyStimulus(8'h02);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        applyStimulus(8'hCC);
        applyStimulus(8'hDD);
        applyStimulus(chk);
    endtask

    // Wait until the FIFO is drained and the loader is idle, bounded
    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        @(negedge clk_rx);
        while ((busy || rd_ptr != wr_ptr) && n < budget) begin
            @(negedge clk_rx);
            n++;
        end
        checkOutput(tag, {30'd0, busy, rd_ptr != wr_ptr}, 32'd0);
        repeat (2) @(negedge clk_rx);
    endtask

    initial begin
        int w0;
        int d0;
        int n;
        logic [7:0] sum;

        rst_clk_rx = 1'b1;
        frm_err    = 1'b0;
        lost_data  = 1'b0;
        repeat (3) @(negedge clk_rx);

        // Reset state
        checkOutput("rst_read_en",   {31'd0, read_en}, 32'd0);
        checkOutput("rst_mem_we",    {31'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr",  {16'd0, mem_addr}, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_busy",      {31'd0, busy}, 32'd0);
        checkOutput("rst_err",       {30'd0, err_code}, 32'd0);
        checkOutput("rst_wcount",    {23'd0, word_count}, 32'd0);
        rst_clk_rx = 1'b0;
        repeat (2) @(negedge clk_rx);

        // Good frame to instruction memory
        w0 = wr_cnt; d0 = done_cnt;
        sendFrameA(8'h01, 8'h57);
        waitIdle("a_idle", 500);
        checkOutput("a_writes", wr_cnt - w0, 2);
        checkOutput("a_addr0",  {16'd0, wr_addr[w0]}, 32'h0010);
        checkOutput("a_data0",  wr_data[w0], 32'h44332211);
        checkOutput("a_sel0",   {31'd0, wr_sel[w0]}, 32'd0);
        checkOutput("a_addr1",  {16'd0, wr_addr[w0+1]}, 32'h0011);
        checkOutput("a_data1",  wr_data[w0+1], 32'hDDCCBBAA);
        checkOutput("a_done",   done_cnt - d0, 1);
        checkOutput("a_err",    {30'd0, err_code}, 32'd0);
        checkOutput("a_wcount", {23'd0, word_count}, 32'd2);

        // Bad checksum: words still land, error 2, no load_done
        w0 = wr_cnt; d0 = done_cnt;
        sendFrameA(8'h01, 8'h56);
        waitIdle("b_idle", 500);
        checkOutput("b_writes", wr_cnt - w0, 2);
        checkOutput("b_done",   done_cnt - d0, 0);
        checkOutput("b_err",    {30'd0, err_code}, 32'd2);
        checkOutput("b_wcount", {23'd0, word_count}, 32'd2);

        // Bad command: drain, then a good data-memory frame clears the error
        w0 = wr_cnt; d0 = done_cnt;
        sendFrameA(8'h07, 8'h57);
        repeat (10) @(negedge clk_rx);
        checkOutput("c_err_drain",  {30'd0, err_code}, 32'd1);
        checkOutput("c_busy_drain", {31'd0, busy}, 32'd1);
        waitIdle("c_idle", 500);
        checkOutput("c_writes", wr_cnt - w0, 0);
        checkOutput("c_err_held", {30'd0, err_code}, 32'd1);
        w0 = wr_cnt;
        sendFrameA(8'h02, 8'h54);
        repeat (2) @(negedge clk_rx);
        checkOutput("c_err_clr", {30'd0, err_code}, 32'd0);
        checkOutput("c_busy",    {31'd0, busy}, 32'd1);
        waitIdle("c2_idle", 500);
        checkOutput("c2_writes", wr_cnt - w0, 2);
        checkOutput("c2_sel",    {31'd0, wr_sel[w0]}, 32'd1);
        checkOutput("c2_data1",  wr_data[w0+1], 32'hDDCCBBAA);
        checkOutput("c2_done",   done_cnt - d0, 1);
        checkOutput("c2_err",    {30'd0, err_code}, 32'd0);

        // Timeout after 5 of 8 payload bytes
        w0 = wr_cnt; d0 = done_cnt;
        applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h00);
        applyStimulus(8'h10); applyStimulus(8'h02);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
        applyStimulus(8'h44); applyStimulus(8'hAA);
        waitIdle("d_idle", 500);
        checkOutput("d_writes", wr_cnt - w0, 1);
        checkOutput("d_err",    {30'd0, err_code}, 32'd3);
        checkOutput("d_busy",   {31'd0, busy}, 32'd0);
        checkOutput("d_tmo_clocks", err3_edge - last_rd_edge, 100);
        checkOutput("d_done",   done_cnt - d0, 0);

        // Line error mid-frame goes to drain; ignored when idle
        applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h00);
        applyStimulus(8'h10); applyStimulus(8'h02);
        applyStimulus(8'h11); applyStimulus(8'h22);
        repeat (12) @(negedge clk_rx);
        checkOutput("e_err_pre", {30'd0, err_code}, 32'd0);
        frm_err = 1'b1;
        @(negedge clk_rx);
        frm_err = 1'b0;
        checkOutput("e_err_line", {30'd0, err_code}, 32'd3);
        checkOutput("e_busy",     {31'd0, busy}, 32'd1);
        waitIdle("e_idle", 500);
        checkOutput("e_err_held", {30'd0, err_code}, 32'd3);
        lost_data = 1'b1;
        repeat (3) @(negedge clk_rx);
        lost_data = 1'b0;
        checkOutput("e_idle_busy", {31'd0, busy}, 32'd0);

        // Garbage, then 256-word frame wrapping the address
        w0 = wr_cnt; d0 = done_cnt;
        applyStimulus(8'h00); applyStimulus(8'hFF); applyStimulus(8'h3C);
        applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'hFF);
        applyStimulus(8'hFF); applyStimulus(8'h00);
        sum = 8'h01 ^ 8'hFF ^ 8'hFF ^ 8'h00;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'(i));
            applyStimulus(8'h00);
            applyStimulus(8'hDE);
            applyStimulus(8'hC0);
            sum = sum ^ 8'(i) ^ 8'hDE ^ 8'hC0;
        end
        applyStimulus(sum);
        waitIdle("f_idle", 5000);
        checkOutput("f_writes",   wr_cnt - w0, 256);
        checkOutput("f_addr0",    {16'd0, wr_addr[w0]}, 32'hFFFF);
        checkOutput("f_addr1",    {16'd0, wr_addr[w0+1]}, 32'h0000);
        checkOutput("f_addr255",  {16'd0, wr_addr[w0+255]}, 32'h00FE);
        checkOutput("f_data0",    wr_data[w0], 32'hC0DE0000);
        checkOutput("f_data255",  wr_data[w0+255], 32'hC0DE00FF);
        checkOutput("f_wcount",   {23'd0, word_count}, 32'd256);
        checkOutput("f_done",     done_cnt - d0, 1);
        checkOutput("f_err",      {30'd0, err_code}, 32'd0);
        checkOutput("f_back2back", back2back, 0);
        checkOutput("f_rd_empty", rd_empty, 0);

        // Reset asserted mid-payload
        w0 = wr_cnt;
        applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'h00);
        applyStimulus(8'h20); applyStimulus(8'h02);
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
        applyStimulus(8'h28);
        n = 0;
        while (wr_cnt == w0 && n < 200) begin
            @(negedge clk_rx);
            n++;
        end
        checkOutput("g_first_write", wr_cnt - w0, 1);
        checkOutput("g_pre_data", mem_wdata, 32'h04030201);
        @(negedge clk_rx);
        checkOutput("g_pre_busy", {31'd0, busy}, 32'd1);
        rst_clk_rx = 1'b1;
        #1;
        checkOutput("g_rst_outs",
                    {read_en, mem_we, mem_sel, busy, load_done, err_code, word_count},
                    32'd0);
        checkOutput("g_rst_addr",  {16'd0, mem_addr}, 32'd0);
        checkOutput("g_rst_wdata", mem_wdata, 32'd0);
        repeat (3) @(negedge clk_rx);
        rst_clk_rx = 1'b0;
        w0 = wr_cnt;
        repeat (100) @(negedge clk_rx);
        checkOutput("g_no_write", wr_cnt - w0, 0);
        checkOutput("g_busy_after", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_file_loader.md
Name: uart_file_loader

Overview:
- Byte-stream controller that drains the UART receiver's output FIFO, parses framed load packets and writes 32-bit words into instruction or data memory.
- Sits between the UART receiver (rx_data / rx_data_rdy / read_en) and the memory write ports of the FileIO path.
- Reports completion, errors and loaded-word count to the top level and to a debug probe.

Parameters:
- ADDR_W, 16, width of the word address carried in the packet and driven on mem_addr.
- TIMEOUT_CYCLES, 1_000_000, maximum idle clocks between bytes inside a frame before the frame is aborted.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk_rx  in  1  system clock.
- rst_clk_rx  in  1  asynchronous, active-high reset.
- rx_data  in  8  head byte of the receiver FIFO; valid while rx_data_rdy=1 (first-word-fall-through).
- rx_data_rdy  in  1  receiver FIFO not empty.
- frm_err  in  1  receiver stop-bit error level.
- lost_data  in  1  receiver FIFO overflow, sticky.
- read_en  out  1  one-cycle pop of the receiver FIFO.
- mem_we  out  1  one-cycle memory write strobe.
- mem_sel  out  1  0 = instruction memory, 1 = data memory.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- busy  out  1  high whenever state is not IDLE.
- load_done  out  1  one-cycle pulse on good checksum.
- err_code  out  2  sticky: 0 none, 1 bad cmd, 2 checksum, 3 timeout/line error; cleared on next SYNC_BYTE.
- word_count  out  9  words written in the last/current frame.

Behaviour:
- Reset (async): every output is 0; state = IDLE; all counters, accumulators and the checksum are 0.
- Frame format: SYNC, CMD, ADDR_H, ADDR_L, LEN, then LEN×4 payload bytes, little-endian (first byte = bits 7:0), then CHK.
  - LEN = 0 means 256 words.
  - CHK is the XOR of every byte from CMD through the last payload byte.
  - CMD 8'h01 selects mem_sel=0; CMD 8'h02 selects mem_sel=1; any other value is a bad command.
- Byte consumption: a byte is consumed when the FSM is in a byte-accepting state and rx_data_rdy=1.
  - read_en=1 for exactly that cycle.
  - The next cycle is a mandatory GAP cycle with read_en=0, so the FIFO empty flag can update.
  - Maximum rate is therefore one byte per 2 clocks. read_en is never asserted while rx_data_rdy=0.
- States:
  - IDLE: consume bytes and discard any that are not SYNC. On SYNC: clear err_code, word_count and the checksum, then go to CMD.
  - CMD: latch the command. If it is bad, set err_code=1 and go to DRAIN; otherwise go to ADDR_H.
  - ADDR_H, ADDR_L: latch the address; only the low ADDR_W bits are used. Then go to LEN.
  - LEN: latch LEN, load the word counter to 256 if LEN=0 else LEN, load the byte index to 0, go to PAYLOAD.
  - PAYLOAD: shift bytes into a 32-bit assembly register.
    - On byte index 3, the following cycle pulses mem_we with mem_addr = current address and mem_wdata = assembled word.
    - Then the address increments (wrapping mod 2^ADDR_W), word_count increments, and the remaining count decrements.
    - When the remaining count reaches 0, go to CHK.
  - CHK: compare the received byte with the accumulator. On match, pulse load_done; otherwise set err_code=2. Return to IDLE.
  - DRAIN: consume and discard bytes until no byte has arrived for TIMEOUT_CYCLES, then go to IDLE. No memory writes occur in DRAIN.
- Timeout: an idle counter resets on every consumed byte. In any state other than IDLE/DRAIN, reaching TIMEOUT_CYCLES sets err_code=3 and returns to IDLE. Words already written stay written.
- Line errors: a rising frm_err or lost_data while busy sets err_code=3 and goes to DRAIN. In IDLE these inputs are ignored.
- mem_we, mem_sel, mem_addr and mem_wdata are registered; mem_addr/mem_wdata hold their last value when mem_we=0.
- Simultaneous events: a timeout and a byte arriving in the same cycle resolve to the byte (counter reset); an error on the same cycle as load_done resolves to the error and suppresses load_done.
- Reset asserted mid-frame: the FSM aborts immediately with no further mem_we; the partial frame is lost.

Test Plan:
- Frame A5 01 00 10 02, payload 11 22 33 44 AA BB CC DD, correct CHK → two mem_we: sel=0 addr=0x0010 data=0x44332211, then addr=0x0011 data=0xDDCCBBAA; load_done pulses once; err_code=0; word_count=2.
- Same frame with CHK XOR 1 → both words written, no load_done, err_code=2.
- A5 07 ... → err_code=1, zero mem_we, DRAIN until idle, then a valid frame loads correctly and err_code clears on its SYNC.
- Stop bytes after 5 of 8 payload bytes with TIMEOUT_CYCLES=100 → exactly one mem_we, err_code=3 at 100 idle clocks, busy=0.
- Garbage 00 FF 3C before A5, LEN=0 with address FFFF, 1024 payload bytes → 256 writes, addresses wrap FFFF→0000→00FE, word_count=256; read_en is never high on two consecutive cycles.
- Assert rst_clk_rx mid-PAYLOAD → all outputs 0 in the same cycle, no mem_we after reset.
